// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment to binary converter.
// Segment patterns are active-low and ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam int NUM_DIGITS = 6;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONV,
        S_DONE
    } conv_state_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational decoder: one active-low segment pattern to a decimal digit.
// Blank and illegal patterns both decode to 0; the flags tell them apart.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] digit,
    output logic       is_blank,
    output logic       is_valid
);

    // Pattern lookup; anything not in the table is reported as invalid
    always_comb begin
        digit    = 4'd0;
        is_blank = 1'b0;
        is_valid = 1'b1;
        case (seg)
            SEG_0:     digit = 4'd0;
            SEG_1:     digit = 4'd1;
            SEG_2:     digit = 4'd2;
            SEG_3:     digit = 4'd3;
            SEG_4:     digit = 4'd4;
            SEG_5:     digit = 4'd5;
            SEG_6:     digit = 4'd6;
            SEG_7:     digit = 4'd7;
            SEG_8:     digit = 4'd8;
            SEG_9:     digit = 4'd9;
            SEG_BLANK: is_blank = 1'b1;
            default:   is_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/displays_binario.sv
// Serial six-digit 7-segment to binary converter.
// One digit per clock, most significant first, acc = acc*10 + digit with
// saturation at 2**n-1 so an overflow can never wrap back into range.
module displays_binario
    import seg7_pkg::*;
#(
    parameter int n = 19
)
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [6:0]   display1,
    input  logic [6:0]   display2,
    input  logic [6:0]   display3,
    input  logic [6:0]   display4,
    input  logic [6:0]   display5,
    input  logic [6:0]   display6,
    output logic         busy,
    output logic         done,
    output logic [n-1:0] binario,
    output logic         err_seg,
    output logic         err_ovf
);

    localparam logic [n+3:0] MAX_VAL = {4'b0000, {n{1'b1}}};
    localparam logic [2:0]   LAST_IDX = 3'(NUM_DIGITS - 1);

    conv_state_t  r_state;
    logic [41:0]  r_shadow;
    logic [2:0]   r_idx;
    logic [n+3:0] r_acc;
    logic         r_errSeg;
    logic         r_errOvf;
    logic         r_seenDigit;
    logic         r_busy;
    logic         r_done;
    logic [n-1:0] r_binario;
    logic         r_errSegOut;
    logic         r_errOvfOut;

    logic [6:0]   w_seg;
    logic [3:0]   w_digit;
    logic         w_isBlank;
    logic         w_isValid;
    logic         w_digitErr;
    logic [n+3:0] w_accMul;
    logic [n+3:0] w_accSum;
    logic         w_over;
    logic [n+3:0] w_accSat;
    logic         w_errSegNext;
    logic         w_errOvfNext;
    logic         w_seenNext;

    // Select the shadow digit for this step; idx 0 is display1 (MS digit)
    always_comb begin
        w_seg = SEG_BLANK;
        case (r_idx)
            3'd0:    w_seg = r_shadow[41:35];
            3'd1:    w_seg = r_shadow[34:28];
            3'd2:    w_seg = r_shadow[27:21];
            3'd3:    w_seg = r_shadow[20:14];
            3'd4:    w_seg = r_shadow[13:7];
            3'd5:    w_seg = r_shadow[6:0];
            default: w_seg = SEG_BLANK;
        endcase
    end

    seg7_decode u_decode (
        .seg      (w_seg),
        .digit    (w_digit),
        .is_blank (w_isBlank),
        .is_valid (w_isValid)
    );

    // Next accumulator and flag values for the digit being processed
    always_comb begin
        w_digitErr   = ~w_isValid | (w_isBlank & r_seenDigit);
        w_accMul     = (r_acc << 3) + (r_acc << 1);
        w_accSum     = w_accMul + {{n{1'b0}}, w_digit};
        w_over       = w_accSum > MAX_VAL;
        w_accSat     = w_over ? MAX_VAL : w_accSum;
        w_errSegNext = r_errSeg | w_digitErr;
        w_errOvfNext = r_errOvf | w_over;
        w_seenNext   = r_seenDigit | (w_isValid & ~w_isBlank);
    end

    // Control FSM with registered outputs; the result is loaded on entry to DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_shadow    <= '0;
            r_idx       <= 3'd0;
            r_acc       <= '0;
            r_errSeg    <= 1'b0;
            r_errOvf    <= 1'b0;
            r_seenDigit <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_binario   <= '0;
            r_errSegOut <= 1'b0;
            r_errOvfOut <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_shadow    <= {display1, display2, display3,
                                        display4, display5, display6};
                        r_idx       <= 3'd0;
                        r_acc       <= '0;
                        r_errSeg    <= 1'b0;
                        r_errOvf    <= 1'b0;
                        r_seenDigit <= 1'b0;
                        r_errSegOut <= 1'b0;
                        r_errOvfOut <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= S_CONV;
                    end
                end
                S_CONV: begin
                    r_acc       <= w_accSat;
                    r_errSeg    <= w_errSegNext;
                    r_errOvf    <= w_errOvfNext;
                    r_seenDigit <= w_seenNext;
                    if (r_idx == LAST_IDX) begin
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_errSegOut <= w_errSegNext;
                        r_errOvfOut <= w_errOvfNext;
                        r_binario   <= (w_errSegNext | w_errOvfNext) ? '0 : w_accSat[n-1:0];
                        r_state     <= S_DONE;
                    end else begin
                        r_idx <= r_idx + 3'd1;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign binario = r_binario;
    assign err_seg = r_errSegOut;
    assign err_ovf = r_errOvfOut;

endmodule

// File: tb/tb_displays_binario.sv
// Directed testbench for displays_binario: hand-computed conversions,
// latency, overflow, blank handling, start hold and mid-run reset.
module tb_displays_binario;

    localparam logic [6:0] D0 = 7'b1000000;
    localparam logic [6:0] D1 = 7'b1111001;
    localparam logic [6:0] D2 = 7'b0100100;
    localparam logic [6:0] D3 = 7'b0110000;
    localparam logic [6:0] D4 = 7'b0011001;
    localparam logic [6:0] D5 = 7'b0010010;
    localparam logic [6:0] D6 = 7'b0000010;
    localparam logic [6:0] D7 = 7'b1111000;
    localparam logic [6:0] D8 = 7'b0000000;
    localparam logic [6:0] D9 = 7'b0010000;
    localparam logic [6:0] DB = 7'b1111111;
    localparam logic [6:0] DX = 7'b1010101;

    logic        clk;
    logic        rst;
    logic        start;
    logic [6:0]  display1, display2, display3, display4, display5, display6;
    logic        busy;
    logic        done;
    logic [18:0] binario;
    logic        err_seg;
    logic        err_ovf;

    int          checks;
    int          failures;
    logic [18:0] prevBin;

    displays_binario #(.n(19)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .display1 (display1),
        .display2 (display2),
        .display3 (display3),
        .display4 (display4),
        .display5 (display5),
        .display6 (display6),
        .busy     (busy),
        .done     (done),
        .binario  (binario),
        .err_seg  (err_seg),
        .err_ovf  (err_ovf)
    );

    // Free-running 10-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic setDisplays(input logic [6:0] a, input logic [6:0] b, input logic [6:0] c,
                               input logic [6:0] d, input logic [6:0] e, input logic [6:0] f);
        display1 = a;
        display2 = b;
        display3 = c;
        display4 = d;
        display5 = e;
        display6 = f;
    endtask

    // One full conversion: start at edge t, busy after edges t..t+5, done after t+6, idle after t+7
    task automatic applyStimulus(input string tag,
                                 input logic [6:0] a, input logic [6:0] b, input logic [6:0] c,
                                 input logic [6:0] d, input logic [6:0] e, input logic [6:0] f,
                                 input logic [18:0] expBin, input logic expSeg, input logic expOvf);
        @(negedge clk);
        setDisplays(a, b, c, d, e, f);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        setDisplays(DX, DX, DX, DX, DX, DX);
        checkOutput({tag, "_busy0"}, busy, 1);
        checkOutput({tag, "_hold"}, binario, prevBin);
        for (int k = 1; k < 6; k++) begin
            @(posedge clk);
            #1;
            checkOutput({tag, "_busyrun"}, {busy, done}, 2'b10);
        end
        @(posedge clk);
        #1;
        checkOutput({tag, "_done"}, {busy, done}, 2'b01);
        checkOutput({tag, "_bin"}, binario, expBin);
        checkOutput({tag, "_errseg"}, err_seg, expSeg);
        checkOutput({tag, "_errovf"}, err_ovf, expOvf);
        @(posedge clk);
        #1;
        checkOutput({tag, "_after"}, {busy, done}, 2'b00);
        prevBin = expBin;
    endtask

    // Linear directed sequence
    initial begin
        checks   = 0;
        failures = 0;
        prevBin  = '0;
        rst      = 1'b1;
        start    = 1'b0;
        setDisplays(DB, DB, DB, DB, DB, DB);

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_outputs", {busy, done, err_seg, err_ovf}, 4'b0000);
        checkOutput("reset_bin", binario, 0);
        @(negedge clk);
        rst = 1'b0;

        applyStimulus("v12345", D0, D1, D2, D3, D4, D5, 19'd12345, 1'b0, 1'b0);
        applyStimulus("vmax", D5, D2, D4, D2, D8, D7, 19'd524287, 1'b0, 1'b0);
        applyStimulus("vmax1", D5, D2, D4, D2, D8, D8, 19'd0, 1'b0, 1'b1);
        applyStimulus("v999999", D9, D9, D9, D9, D9, D9, 19'd0, 1'b0, 1'b1);
        applyStimulus("vlead", DB, DB, DB, D4, D2, D7, 19'd427, 1'b0, 1'b0);
        applyStimulus("vblankmid", D4, DB, D1, D1, D1, D1, 19'd0, 1'b1, 1'b0);
        applyStimulus("vallblank", DB, DB, DB, DB, DB, DB, 19'd0, 1'b0, 1'b0);
        applyStimulus("villegal", D0, D0, DX, D0, D0, D0, 19'd0, 1'b1, 1'b0);
        applyStimulus("v908", D0, D0, D0, D9, D0, D8, 19'd908, 1'b0, 1'b0);

        // start held for 20 edges: runs accepted at edges t, t+8, t+16
        @(negedge clk);
        setDisplays(D1, D2, D3, D4, D5, D6);
        start = 1'b1;
        for (int k = 0; k < 24; k++) begin
            @(posedge clk);
            #1;
            if (k + 1 >= 20) start = 1'b0;
            checkOutput("hold_busy", busy, ((k % 8) < 6) ? 1 : 0);
            checkOutput("hold_done", done, ((k % 8) == 6) ? 1 : 0);
            if ((k % 8) == 6) begin
                checkOutput("hold_bin", binario, 123456);
                checkOutput("hold_err", {err_seg, err_ovf}, 2'b00);
            end
        end
        prevBin = 19'd123456;

        // reset asserted in cycle t+4 aborts the conversion
        @(negedge clk);
        setDisplays(D0, D4, D0, D0, D0, D0);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("abort_busy", busy, 1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("abort_ctrl", {busy, done, err_seg, err_ovf}, 4'b0000);
        checkOutput("abort_bin", binario, 0);
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            checkOutput("abort_nodone", {busy, done}, 2'b00);
        end
        prevBin = '0;

        applyStimulus("vpostabort", D0, D4, D0, D0, D0, D0, 19'd40000, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
